// File: rtl/dapuf_eval_ctrl_if.sv
// Host request/response and PUF challenge/excite signals of the DAPUF evaluation controller.
// The controller takes the master modport; the host and PUF environment take the slave modport.
interface dapuf_eval_ctrl_if #(
    parameter int CHAL_W    = 32,
    parameter int RESP_BITS = 32
);
    localparam int CNT_W = $clog2(RESP_BITS + 1);

    logic                 start;
    logic [CHAL_W-1:0]    seed;
    logic                 abort;
    logic                 start_ready;
    logic                 busy;
    logic [CHAL_W-1:0]    puf_challenge;
    logic                 puf_exciteL;
    logic                 puf_exciteR;
    logic                 puf_response;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] resp_data;
    logic [CNT_W-1:0]     unstable_cnt;

    modport master (
        input  start, seed, abort, puf_response, resp_ready,
        output start_ready, busy, puf_challenge, puf_exciteL, puf_exciteR,
               resp_valid, resp_data, unstable_cnt
    );

    modport slave (
        output start, seed, abort, puf_response, resp_ready,
        input  start_ready, busy, puf_challenge, puf_exciteL, puf_exciteR,
               resp_valid, resp_data, unstable_cnt
    );
endinterface

// File: rtl/dapuf_eval_ctrl.sv
// Double-arbiter PUF initiator: walks an LFSR challenge sequence, fires each challenge VOTES
// times, majority-votes the synchronised responses and hands off one packed response word.
module dapuf_eval_ctrl #(
    parameter int CHAL_W     = 32,
    parameter int RESP_BITS  = 32,
    parameter int SETTLE_CYC = 4,
    parameter int EVAL_CYC   = 8,
    parameter int VOTES      = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dapuf_eval_ctrl_if.master ctrl_if
);
    localparam int CNT_W  = $clog2(RESP_BITS + 1);
    localparam int PH_MAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int VOTE_W = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int ONES_W = $clog2(VOTES + 1);
    localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]   EVAL_LAST   = PH_W'(EVAL_CYC - 1);
    localparam logic [VOTE_W-1:0] VOTE_LAST   = VOTE_W'(VOTES - 1);
    localparam logic [ONES_W-1:0] VOTE_ALL    = ONES_W'(VOTES);
    localparam logic [ONES_W-1:0] VOTE_HALF   = ONES_W'(VOTES / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(RESP_BITS - 1);
    localparam logic [CHAL_W-1:0] LFSR_MASK   = CHAL_W'(32'h8020_0003);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        FIRE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CHAL_W-1:0]    chal_q, chal_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [VOTE_W-1:0]    vote_q, vote_d;
    logic [ONES_W-1:0]    ones_q, ones_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [RESP_BITS-1:0] respData_q, respData_d;
    logic [CNT_W-1:0]     unstable_q, unstable_d;
    logic                 respValid_q, respValid_d;
    logic                 excite_q, excite_d;
    logic                 sync1_q, sync2_q;

    logic [ONES_W-1:0]    onesTotal;
    logic                 votedBit;
    logic                 splitVote;
    logic [CHAL_W-1:0]    lfsrNext;
    logic                 handshake;

    // Includes the sample taken on the final FIRE cycle, which has not reached ones_q yet.
    assign onesTotal = ones_q + ONES_W'(sync2_q);
    assign votedBit  = (onesTotal > VOTE_HALF);
    assign splitVote = (onesTotal != '0) && (onesTotal != VOTE_ALL);
    assign lfsrNext  = chal_q[0] ? ((chal_q >> 1) ^ LFSR_MASK) : (chal_q >> 1);
    assign handshake = respValid_q && ctrl_if.resp_ready;

    always_comb begin
        state_d     = state_q;
        chal_d      = chal_q;
        phase_d     = phase_q;
        vote_d      = vote_q;
        ones_d      = ones_q;
        bit_d       = bit_q;
        respData_d  = respData_q;
        unstable_d  = unstable_q;
        respValid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctrl_if.start) begin
                    chal_d     = (ctrl_if.seed == '0) ? CHAL_W'(1) : ctrl_if.seed;
                    respData_d = '0;
                    unstable_d = '0;
                    phase_d    = '0;
                    vote_d     = '0;
                    ones_d     = '0;
                    bit_d      = '0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (ctrl_if.abort) begin
                    phase_d = '0;
                    state_d = IDLE;
                end else if (phase_q == SETTLE_LAST) begin
                    phase_d = '0;
                    state_d = FIRE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            FIRE: begin
                if (ctrl_if.abort) begin
                    phase_d = '0;
                    state_d = IDLE;
                end else if (phase_q == EVAL_LAST) begin
                    phase_d = '0;
                    state_d = SETTLE;
                    if (vote_q != VOTE_LAST) begin
                        vote_d = vote_q + VOTE_W'(1);
                        ones_d = onesTotal;
                    end else begin
                        respData_d[bit_q] = votedBit;
                        if (splitVote) begin
                            unstable_d = unstable_q + CNT_W'(1);
                        end
                        chal_d = lfsrNext;
                        vote_d = '0;
                        ones_d = '0;
                        bit_d  = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = DONE;
                        end
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            DONE: begin
                respValid_d = !handshake;
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign excite_d = (state_d == FIRE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            chal_q      <= '0;
            phase_q     <= '0;
            vote_q      <= '0;
            ones_q      <= '0;
            bit_q       <= '0;
            respData_q  <= '0;
            unstable_q  <= '0;
            respValid_q <= 1'b0;
            excite_q    <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            chal_q      <= chal_d;
            phase_q     <= phase_d;
            vote_q      <= vote_d;
            ones_q      <= ones_d;
            bit_q       <= bit_d;
            respData_q  <= respData_d;
            unstable_q  <= unstable_d;
            respValid_q <= respValid_d;
            excite_q    <= excite_d;
            sync1_q     <= ctrl_if.puf_response;
            sync2_q     <= sync1_q;
        end
    end

    assign ctrl_if.start_ready   = (state_q == IDLE);
    assign ctrl_if.busy          = (state_q == SETTLE) || (state_q == FIRE);
    assign ctrl_if.puf_challenge = chal_q;
    assign ctrl_if.puf_exciteL   = excite_q;
    assign ctrl_if.puf_exciteR   = excite_q;
    assign ctrl_if.resp_valid    = respValid_q;
    assign ctrl_if.resp_data     = respData_q;
    assign ctrl_if.unstable_cnt  = unstable_q;
endmodule
